reorder_buffer: RTL and testbench



---
 rtl/reorder_buffer.sv | 101 ++++++++++
 tb/tb_reorder_buffer.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: allocates rename tags, captures CDB results by tag,
// and retires entries in program order to the register file write port.
module reorder_buffer #(
  parameter int DEPTH = 8,
  parameter int TAG_W = 3,
  parameter int NCDB  = 5,
  parameter int XLEN  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  issue_valid,
  input  logic [4:0]            issue_rd,
  output logic                  issue_ready,
  output logic [TAG_W-1:0]      issue_tag,
  input  logic [NCDB-1:0]       cdb_valid,
  input  logic [NCDB*TAG_W-1:0] cdb_tag,
  input  logic [NCDB*XLEN-1:0]  cdb_data,
  input  logic [TAG_W-1:0]      lookup_tag,
  output logic                  lookup_ready,
  output logic [XLEN-1:0]       lookup_data,
  output logic                  write,
  output logic [4:0]            write_addr,
  output logic [XLEN-1:0]       write_data,
  output logic [TAG_W:0]        count,
  output logic                  empty
);

  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] done_q;
  logic [4:0]       rd_q   [DEPTH];
  logic [XLEN-1:0]  data_q [DEPTH];
  logic [TAG_W-1:0] head;
  logic [TAG_W-1:0] tail;

  logic             fire;
  logic             commit;
  logic [DEPTH-1:0] cap_en;
  logic [XLEN-1:0]  cap_data [DEPTH];

  assign issue_ready  = count < (TAG_W+1)'(DEPTH);
  assign issue_tag    = tail;
  assign fire         = issue_valid && issue_ready;
  assign commit       = valid_q[head] && done_q[head];
  assign lookup_ready = valid_q[lookup_tag] && done_q[lookup_tag];
  assign lookup_data  = data_q[lookup_tag];
  assign empty        = count == '0;

  // Scan channels high to low so the lowest matching channel wins.
  always_comb begin
    for (int e = 0; e < DEPTH; e++) begin
      cap_en[e]   = 1'b0;
      cap_data[e] = '0;
      for (int i = NCDB-1; i >= 0; i--) begin
        if (cdb_valid[i] &&
            cdb_tag[i*TAG_W +: TAG_W] == TAG_W'(e)) begin
          cap_en[e]   = 1'b1;
          cap_data[e] = cdb_data[i*XLEN +: XLEN];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      valid_q    <= '0;
      done_q     <= '0;
      write      <= 1'b0;
      write_addr <= '0;
      write_data <= '0;
    end else begin
      write <= 1'b0;
      for (int e = 0; e < DEPTH; e++) begin
        if (valid_q[e] && !done_q[e] && cap_en[e]) begin
          done_q[e] <= 1'b1;
          data_q[e] <= cap_data[e];
        end
      end
      if (commit) begin
        valid_q[head] <= 1'b0;
        head          <= head + TAG_W'(1);
        // x0 retires silently; address/data hold their last values.
        if (rd_q[head] != 5'd0) begin
          write      <= 1'b1;
          write_addr <= rd_q[head];
          write_data <= data_q[head];
        end
      end
      if (fire) begin
        valid_q[tail] <= 1'b1;
        done_q[tail]  <= 1'b0;
        rd_q[tail]    <= issue_rd;
        tail          <= tail + TAG_W'(1);
      end
      count <= count + (TAG_W+1)'(fire) - (TAG_W+1)'(commit);
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Scoreboard bench for reorder_buffer: expected writes queued at issue,
// popped and compared whenever the register-file write strobe fires.
module tb_reorder_buffer;
  localparam int DEPTH = 8;
  localparam int TAG_W = 3;
  localparam int NCDB  = 5;
  localparam int XLEN  = 32;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  issue_valid;
  logic [4:0]            issue_rd;
  logic                  issue_ready;
  logic [TAG_W-1:0]      issue_tag;
  logic [NCDB-1:0]       cdb_valid;
  logic [NCDB*TAG_W-1:0] cdb_tag;
  logic [NCDB*XLEN-1:0]  cdb_data;
  logic [TAG_W-1:0]      lookup_tag;
  logic                  lookup_ready;
  logic [XLEN-1:0]       lookup_data;
  logic                  write;
  logic [4:0]            write_addr;
  logic [XLEN-1:0]       write_data;
  logic [TAG_W:0]        count;
  logic                  empty;

  logic [NCDB-1:0]  cv;
  logic [TAG_W-1:0] ct [NCDB];
  logic [XLEN-1:0]  cd [NCDB];

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [4:0]       rd;
  } exp_t;

  exp_t             exp_q[$];
  logic             m_valid [DEPTH];
  logic             m_done  [DEPTH];
  logic [XLEN-1:0]  m_data  [DEPTH];
  logic [TAG_W-1:0] m_tail;
  int               checks = 0;
  int               failures = 0;

  reorder_buffer #(
    .DEPTH(DEPTH), .TAG_W(TAG_W), .NCDB(NCDB), .XLEN(XLEN)
  ) dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .issue_ready(issue_ready), .issue_tag(issue_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .lookup_tag(lookup_tag), .lookup_ready(lookup_ready),
    .lookup_data(lookup_data),
    .write(write), .write_addr(write_addr), .write_data(write_data),
    .count(count), .empty(empty)
  );

  always #5 clk = ~clk;

  always_comb begin
    cdb_valid = cv;
    cdb_tag   = '0;
    cdb_data  = '0;
    for (int i = 0; i < NCDB; i++) begin
      cdb_tag[i*TAG_W +: TAG_W] = ct[i];
      cdb_data[i*XLEN +: XLEN]  = cd[i];
    end
  end

  task automatic check(string name, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (write === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("spurious_write", 64'(write), 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("wr_after_done", 64'(m_done[e.tag]), 64'd1);
        check("wr_addr", 64'(write_addr), 64'(e.rd));
        check("wr_data", 64'(write_data), 64'(m_data[e.tag]));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    for (int i = 0; i < DEPTH; i++) begin
      m_valid[i] = 1'b0;
      m_done[i]  = 1'b0;
      m_data[i]  = '0;
    end
    m_tail = '0;
    exp_q.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    clear_model();
  endtask

  task automatic accept(input logic [4:0] rd);
    m_valid[m_tail] = 1'b1;
    m_done[m_tail]  = 1'b0;
    if (rd != 5'd0) exp_q.push_back({m_tail, rd});
    m_tail = m_tail + 3'd1;
  endtask

  task automatic do_issue(input logic [4:0] rd);
    check("issue_ready", 64'(issue_ready), 64'd1);
    check("issue_tag", 64'(issue_tag), 64'(m_tail));
    issue_valid = 1'b1;
    issue_rd    = rd;
    tick();
    issue_valid = 1'b0;
    accept(rd);
  endtask

  task automatic set_ch(input int ch, input logic [TAG_W-1:0] tag,
                        input logic [XLEN-1:0] data);
    cv[ch] = 1'b1;
    ct[ch] = tag;
    cd[ch] = data;
  endtask

  task automatic bcast();
    for (int i = 0; i < NCDB; i++) begin
      if (cv[i] && m_valid[ct[i]] && !m_done[ct[i]]) begin
        m_done[ct[i]] = 1'b1;
        m_data[ct[i]] = cd[i];
      end
    end
    tick();
    cv = '0;
  endtask

  initial begin
    rst = 1'b1;
    issue_valid = 1'b0;
    issue_rd = '0;
    lookup_tag = '0;
    cv = '0;
    for (int i = 0; i < NCDB; i++) begin
      ct[i] = '0;
      cd[i] = '0;
    end
    clear_model();
    tick();
    tick();
    rst = 1'b0;
    check("rst_count", 64'(count), 64'd0);
    check("rst_empty", 64'(empty), 64'd1);
    check("rst_write", 64'(write), 64'd0);
    check("rst_waddr", 64'(write_addr), 64'd0);
    check("rst_wdata", 64'(write_data), 64'd0);

    // single instruction round trip
    do_issue(5'd5);
    check("t1_count", 64'(count), 64'd1);
    check("t1_empty", 64'(empty), 64'd0);
    set_ch(2, 3'd0, 32'hAA);
    bcast();
    lookup_tag = 3'd0;
    #0;
    check("t1_lk_rdy", 64'(lookup_ready), 64'd1);
    check("t1_lk_data", 64'(lookup_data), 64'hAA);
    tick();
    check("t1_write", 64'(write), 64'd1);
    check("t1_waddr", 64'(write_addr), 64'd5);
    check("t1_wdata", 64'(write_data), 64'hAA);
    check("t1_count0", 64'(count), 64'd0);
    check("t1_empty1", 64'(empty), 64'd1);

    // out-of-order completion, in-order retirement
    do_issue(5'd1);
    do_issue(5'd2);
    do_issue(5'd3);
    set_ch(0, 3'd3, 32'h33);
    bcast();
    set_ch(1, 3'd2, 32'h22);
    bcast();
    check("t2_nowrite", 64'(write), 64'd0);
    set_ch(3, 3'd1, 32'h11);
    bcast();
    repeat (5) tick();
    check("t2_count", 64'(count), 64'd0);

    // full buffer, refusal during commit, wrap-around
    do_reset();
    for (int i = 0; i < DEPTH; i++) do_issue(5'(8 + i));
    check("t3_count8", 64'(count), 64'd8);
    check("t3_full_rdy", 64'(issue_ready), 64'd0);
    issue_valid = 1'b1;
    issue_rd    = 5'd20;
    tick();
    check("t3_cnt_hold", 64'(count), 64'd8);
    check("t3_tail_hold", 64'(issue_tag), 64'd0);
    set_ch(0, 3'd0, 32'h100);
    bcast();
    check("t3_commit_rdy", 64'(issue_ready), 64'd0);
    tick();
    check("t3_cnt7", 64'(count), 64'd7);
    check("t3_rdy", 64'(issue_ready), 64'd1);
    check("t3_wrap_tag", 64'(issue_tag), 64'd0);
    tick();
    issue_valid = 1'b0;
    accept(5'd20);
    check("t3_cnt_refill", 64'(count), 64'd8);
    for (int t = 1; t < DEPTH; t++) begin
      set_ch(t % NCDB, 3'(t), 32'h200 + 32'(t));
      bcast();
    end
    set_ch(0, 3'd0, 32'h300);
    bcast();
    repeat (4) tick();
    check("t3_drain_cnt", 64'(count), 64'd0);
    check("t3_drain_q", 64'(exp_q.size()), 64'd0);

    // duplicate tags: lowest channel wins; done entries ignore rebroadcast
    do_reset();
    for (int i = 1; i <= 4; i++) do_issue(5'(i));
    set_ch(0, 3'd3, 32'd11);
    set_ch(4, 3'd3, 32'd22);
    set_ch(1, 3'd1, 32'h101);
    set_ch(2, 3'd2, 32'h102);
    bcast();
    lookup_tag = 3'd3;
    #0;
    check("t4_lk_rdy", 64'(lookup_ready), 64'd1);
    check("t4_lk_data", 64'(lookup_data), 64'd11);
    check("t4_nowrite", 64'(write), 64'd0);
    set_ch(3, 3'd3, 32'd33);
    bcast();
    check("t4_lk_keep", 64'(lookup_data), 64'd11);
    set_ch(0, 3'd0, 32'h100);
    bcast();
    repeat (5) tick();
    check("t4_lk_gone", 64'(lookup_ready), 64'd0);
    check("t4_count", 64'(count), 64'd0);

    // distinct tags on all five channels at once
    do_reset();
    for (int i = 0; i < NCDB; i++) do_issue(5'(21 + i));
    for (int i = 0; i < NCDB; i++) set_ch(i, 3'(4 - i), 32'h500 + 32'(i));
    bcast();
    repeat (7) tick();
    check("t5_count", 64'(count), 64'd0);
    check("t5_q", 64'(exp_q.size()), 64'd0);

    // x0 destination retires without a write
    do_reset();
    do_issue(5'd0);
    do_issue(5'd7);
    set_ch(0, 3'd0, 32'h77);
    bcast();
    check("t6_cnt2", 64'(count), 64'd2);
    tick();
    check("t6_cnt1", 64'(count), 64'd1);
    check("t6_nowrite", 64'(write), 64'd0);
    check("t6_empty", 64'(empty), 64'd0);
    set_ch(1, 3'd1, 32'h88);
    bcast();
    tick();
    check("t6_write", 64'(write), 64'd1);
    check("t6_waddr", 64'(write_addr), 64'd7);
    check("t6_wdata", 64'(write_data), 64'h88);
    check("t6_cnt0", 64'(count), 64'd0);

    // reset mid-operation overrides issue and CDB activity
    do_reset();
    for (int i = 1; i <= 4; i++) do_issue(5'(i));
    rst = 1'b1;
    issue_valid = 1'b1;
    issue_rd = 5'd9;
    set_ch(0, 3'd0, 32'hDEAD);
    tick();
    rst = 1'b0;
    issue_valid = 1'b0;
    cv = '0;
    clear_model();
    lookup_tag = 3'd1;
    #0;
    check("t7_count", 64'(count), 64'd0);
    check("t7_write", 64'(write), 64'd0);
    check("t7_tag", 64'(issue_tag), 64'd0);
    check("t7_empty", 64'(empty), 64'd1);
    set_ch(1, 3'd1, 32'hBEEF);
    bcast();
    repeat (3) tick();
    check("t7_stale_cnt", 64'(count), 64'd0);
    check("t7_stale_lk", 64'(lookup_ready), 64'd0);
    do_issue(5'd6);
    set_ch(0, 3'd0, 32'h66);
    bcast();
    repeat (3) tick();
    check("t7_after_cnt", 64'(count), 64'd0);
    check("final_q", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
